// File: rtl/password_enumerator_if.sv
// password_enumerator_if
//   Candidate stream between password_enumerator (master) and its consumer,
//   normally the MD4 loader (slave).
//   start        : one-cycle request to begin enumeration (consumer -> enumerator)
//   out_ready    : consumer accepts the current candidate
//   out_valid    : candidate on passwd_chars/passwd_len is valid
//   passwd_chars : packed candidate, char 0 in [159:152], zero-padded past passwd_len
//   passwd_len   : candidate length in bytes
//   exhausted    : every candidate has been accepted
//   count        : accepted candidates since the last start, saturating
interface password_enumerator_if;
  logic         start;
  logic         out_ready;
  logic         out_valid;
  logic [159:0] passwd_chars;
  logic [7:0]   passwd_len;
  logic         exhausted;
  logic [31:0]  count;

  modport master (
    input  start, out_ready,
    output out_valid, passwd_chars, passwd_len, exhausted, count
  );

  modport slave (
    output start, out_ready,
    input  out_valid, passwd_chars, passwd_len, exhausted, count
  );
endinterface

// File: rtl/password_enumerator.sv
// password_enumerator
//   Walks every string over the byte range CHAR_FIRST..CHAR_LAST, shortest
//   first and lexicographic within a length, from MIN_LEN to MAX_LEN bytes.
//   One candidate is presented per accepted handshake, in the packed form the
//   MD4 loader consumes. Exhaustion is flagged after the final accept.
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : candidate stream (master side), see password_enumerator_if
module password_enumerator #(
  parameter int         MIN_LEN    = 1,
  parameter int         MAX_LEN    = 20,
  parameter logic [7:0] CHAR_FIRST = 8'h61,
  parameter logic [7:0] CHAR_LAST  = 8'h7a
) (
  input  logic                  clk,
  input  logic                  reset_n,
  password_enumerator_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [159:0] chars_q, chars_d;
  logic [7:0]   len_q, len_d;
  logic [31:0]  count_q, count_d;
  logic         valid_q, valid_d;
  logic         exh_q, exh_d;

  logic [159:0] bump_chars;   // odometer step within the current length
  logic         carry;        // carry out of char 0: every position was CHAR_LAST
  logic [159:0] grow_chars;   // first candidate of length len_q+1
  logic [159:0] first_chars;  // first candidate of length MIN_LEN

  // Odometer: char len_q-1 is least significant; positions past len_q are
  // skipped so the zero padding is never disturbed.
  always_comb begin
    bump_chars  = chars_q;
    carry       = 1'b1;
    grow_chars  = '0;
    first_chars = '0;
    for (int i = 19; i >= 0; i--) begin
      if (8'(i) < len_q && carry) begin
        if (chars_q[159-8*i -: 8] == CHAR_LAST) begin
          bump_chars[159-8*i -: 8] = CHAR_FIRST;
        end else begin
          bump_chars[159-8*i -: 8] = chars_q[159-8*i -: 8] + 8'd1;
          carry = 1'b0;
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      if (8'(i) <= len_q) grow_chars[159-8*i -: 8] = CHAR_FIRST;
      if (i < MIN_LEN)    first_chars[159-8*i -: 8] = CHAR_FIRST;
    end
  end

  // Next-state and register updates; everything holds unless changed below.
  always_comb begin
    state_d = state_q;
    chars_d = chars_q;
    len_d   = len_q;
    count_d = count_q;
    valid_d = valid_q;
    exh_d   = exh_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          chars_d = first_chars;
          len_d   = 8'(MIN_LEN);
          count_d = '0;
          valid_d = 1'b1;
          exh_d   = 1'b0;
        end
      end
      RUN: begin
        // start is deliberately ignored here: enumeration never restarts mid-run.
        if (valid_q && bus.out_ready) begin
          if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
          if (!carry) begin
            chars_d = bump_chars;
          end else if (len_q < 8'(MAX_LEN)) begin
            len_d   = len_q + 8'd1;
            chars_d = grow_chars;
          end else begin
            // Last candidate stays on the data outputs.
            state_d = DONE;
            valid_d = 1'b0;
            exh_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      chars_q <= '0;
      len_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      exh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chars_q <= chars_d;
      len_q   <= len_d;
      count_q <= count_d;
      valid_q <= valid_d;
      exh_q   <= exh_d;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.passwd_chars = chars_q;
  assign bus.passwd_len   = len_q;
  assign bus.count        = count_q;
  assign bus.exhausted    = exh_q;

endmodule

// File: tb/tb_password_enumerator.sv
module tb_password_enumerator;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  password_enumerator_if a ();
  password_enumerator_if f ();

  password_enumerator #(.MIN_LEN(1), .MAX_LEN(2), .CHAR_FIRST(8'h61), .CHAR_LAST(8'h63))
    u_a (.clk(clk), .reset_n(reset_n), .bus(a));

  password_enumerator #(.MIN_LEN(20), .MAX_LEN(20), .CHAR_FIRST(8'h66), .CHAR_LAST(8'h66))
    u_f (.clk(clk), .reset_n(reset_n), .bus(f));

  int vectors = 0;
  int miscompares = 0;

  logic [159:0] exp_w [$];
  logic [7:0]   exp_l [$];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Candidate k of length L is k written in base n, most significant digit first.
  function automatic logic [159:0] model_word(int n, int first, int len, int k);
    logic [159:0] w;
    int v;
    w = '0;
    v = k;
    for (int p = len - 1; p >= 0; p--) begin
      w[159-8*p -: 8] = 8'(first + v % n);
      v = v / n;
    end
    return w;
  endfunction

  task automatic check_cand(input string tag, input int idx);
    check({tag, "_valid"}, 160'(a.out_valid), 160'(1'b1));
    check({tag, "_chars"}, a.passwd_chars, exp_w[idx]);
    check({tag, "_len"},   160'(a.passwd_len), 160'(exp_l[idx]));
    check({tag, "_count"}, 160'(a.count), 160'(32'(idx)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    a.start = 1'b1;
    step();
    a.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int idx;
    int cycles;
    logic [159:0] pre_chars;
    logic [7:0]   pre_len;
    logic         rdy;

    for (int len = 1; len <= 2; len++)
      for (int k = 0; k < 3 ** len; k++) begin
        exp_w.push_back(model_word(3, 'h61, len, k));
        exp_l.push_back(8'(len));
      end

    a.start = 1'b0; a.out_ready = 1'b0;
    f.start = 1'b0; f.out_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_valid", 160'(a.out_valid), 160'(1'b0));
    check("rst_exh",   160'(a.exhausted), 160'(1'b0));
    check("rst_chars", a.passwd_chars, 160'(0));
    check("rst_len",   160'(a.passwd_len), 160'(0));
    check("rst_count", 160'(a.count), 160'(0));
    check("rst_f_valid", 160'(f.out_valid), 160'(1'b0));
    reset_n = 1'b1;
    step();
    check("idle_valid", 160'(a.out_valid), 160'(1'b0));

    // Basic sweep, one candidate per cycle
    a.out_ready = 1'b1;
    pulse_start_a();
    for (int k = 0; k < 12; k++) begin
      check_cand($sformatf("sweep%0d", k), k);
      if (k == 2) check("pack_c",  a.passwd_chars, {8'h63, 152'h0});
      if (k == 4) check("pack_ab", a.passwd_chars, {16'h6162, 144'h0});
      step();
    end
    check("end_exh",   160'(a.exhausted), 160'(1'b1));
    check("end_valid", 160'(a.out_valid), 160'(1'b0));
    check("end_count", 160'(a.count), 160'(32'd12));
    check("end_hold",  a.passwd_chars, exp_w[11]);

    // Start in DONE restarts
    a.out_ready = 1'b0;
    pulse_start_a();
    check("restart_exh", 160'(a.exhausted), 160'(1'b0));
    check_cand("restart", 0);

    // Three accepts, then start in RUN must be ignored
    a.out_ready = 1'b1;
    step(); step(); step();
    a.out_ready = 1'b0;
    pulse_start_a();
    check_cand("run_start", 3);

    // Randomized backpressure through the rest of the sweep
    idx = 3;
    cycles = 0;
    while (!a.exhausted && cycles < 200) begin
      rdy = 1'($urandom_range(0, 1));
      a.out_ready = rdy;
      pre_chars = a.passwd_chars;
      pre_len = a.passwd_len;
      step();
      cycles++;
      if (rdy) idx++;
      if (idx < 12) begin
        check_cand($sformatf("bp%0d", idx), idx);
        if (!rdy) begin
          check("bp_stable_chars", a.passwd_chars, pre_chars);
          check("bp_stable_len", 160'(a.passwd_len), 160'(pre_len));
        end
      end else begin
        check("bp_exh", 160'(a.exhausted), 160'(1'b1));
      end
    end
    check("bp_done",  160'(a.exhausted), 160'(1'b1));
    check("bp_count", 160'(a.count), 160'(32'd12));
    check("bp_valid", 160'(a.out_valid), 160'(1'b0));

    // Reset mid-run after five accepts
    a.out_ready = 1'b1;
    pulse_start_a();
    step(); step(); step(); step(); step();
    check_cand("pre_rst", 5);
    a.out_ready = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 160'(a.out_valid), 160'(1'b0));
    check("mid_rst_chars", a.passwd_chars, 160'(0));
    check("mid_rst_len",   160'(a.passwd_len), 160'(0));
    check("mid_rst_count", 160'(a.count), 160'(0));
    check("mid_rst_exh",   160'(a.exhausted), 160'(1'b0));
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_idle", 160'(a.out_valid), 160'(1'b0));
    pulse_start_a();
    check_cand("post_rst", 0);

    // Full-length single-candidate configuration
    f.start = 1'b1;
    step();
    f.start = 1'b0;
    check("full_valid", 160'(f.out_valid), 160'(1'b1));
    check("full_chars", f.passwd_chars, {20{8'h66}});
    check("full_len",   160'(f.passwd_len), 160'(8'd20));
    check("full_count0", 160'(f.count), 160'(0));
    f.out_ready = 1'b1;
    step();
    f.out_ready = 1'b0;
    check("full_exh",   160'(f.exhausted), 160'(1'b1));
    check("full_count", 160'(f.count), 160'(32'd1));
    check("full_vld0",  160'(f.out_valid), 160'(1'b0));
    check("full_hold",  f.passwd_chars, {20{8'h66}});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
